// File: rtl/softmax_normalizer.sv
// Softmax normalizer: buffers one vector of S5.10 exponentials, divides 2^20 by their sum
// (restoring, 21 cycles) and emits min(1.0, x*recip>>10). Define SOFTMAX_ROUND_EN for round-half-up output.
module softmax_normalizer #(
    parameter int VEC_LEN = 16,
    parameter int DATA_W  = 16,
    parameter int SUM_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              err_zero_sum
);

    localparam int IDX_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int CNT_W  = $clog2(VEC_LEN + 1);
    localparam int Q_W    = 21;
    localparam int PROD_W = DATA_W + Q_W;

    typedef enum logic [1:0] {ACCUM, DIVIDE, EMIT} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [SUM_W-1:0]    rem_q, rem_d;
    logic [Q_W-1:0]      quot_q, quot_d;
    logic [4:0]          div_cnt_q, div_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   buf_mem_q [VEC_LEN];

    logic accept, close, out_fire, final_hs, load, div_done;

    assign accept   = in_valid && (state_q == ACCUM);
    assign close    = accept && (in_last || (count_q == CNT_W'(VEC_LEN - 1)));
    assign out_fire = out_valid_q && out_ready;
    assign final_hs = out_fire && out_last_q;
    assign load     = (state_q == EMIT) && (!out_valid_q || out_ready) && (rd_idx_q < len_q);
    assign div_done = (sum_q == '0) || (div_cnt_q == 5'd20);

    // One restoring step: the dividend 2^20 contributes a single 1 on the first step.
    logic [SUM_W:0]   trial;
    logic             trial_ge;
    logic [SUM_W-1:0] rem_next;
    assign trial    = {rem_q, div_cnt_q == 5'd0};
    assign trial_ge = trial >= {1'b0, sum_q};
    assign rem_next = trial_ge ? SUM_W'(trial - {1'b0, sum_q}) : trial[SUM_W-1:0];

    logic [DATA_W-1:0] elem;
    logic [PROD_W-1:0] prod, prod_adj, scaled;
    logic [DATA_W-1:0] prob;
    assign elem = buf_mem_q[rd_idx_q[IDX_W-1:0]];
    assign prod = PROD_W'(elem) * PROD_W'(quot_q);
`ifdef SOFTMAX_ROUND_EN
    assign prod_adj = prod + PROD_W'(512);
`else
    assign prod_adj = prod;
`endif
    assign scaled = prod_adj >> 10;
    assign prob   = (scaled > PROD_W'(1024)) ? DATA_W'(1024) : scaled[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (close)    state_d = DIVIDE;
            DIVIDE:  if (div_done) state_d = EMIT;
            EMIT:    if (final_hs) state_d = ACCUM;
            default:               state_d = ACCUM;
        endcase
    end

    always_comb begin
        count_d     = count_q;
        len_d       = len_q;
        rd_idx_d    = rd_idx_q;
        sum_d       = sum_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        div_cnt_d   = div_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        err_d       = err_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    sum_d   = sum_q + SUM_W'(in_data);
                    count_d = count_q + CNT_W'(1);
                    busy_d  = 1'b1;
                end
                if (close) begin
                    len_d     = count_q + CNT_W'(1);
                    rem_d     = '0;
                    quot_d    = '0;
                    div_cnt_d = '0;
                    rd_idx_d  = '0;
                end
            end
            DIVIDE: begin
                if (sum_q == '0) begin
                    quot_d = '0;
                    err_d  = 1'b1;
                end else begin
                    rem_d     = rem_next;
                    quot_d    = {quot_q[Q_W-2:0], trial_ge};
                    div_cnt_d = div_cnt_q + 5'd1;
                end
            end
            EMIT: begin
                if (load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = prob;
                    out_last_d  = (rd_idx_q + CNT_W'(1)) == len_q;
                    rd_idx_d    = rd_idx_q + CNT_W'(1);
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (final_hs) begin
                    count_d  = '0;
                    sum_d    = '0;
                    busy_d   = 1'b0;
                    err_d    = 1'b0;
                    rd_idx_d = '0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            len_q       <= '0;
            rd_idx_q    <= '0;
            sum_q       <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            div_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            len_q       <= len_d;
            rd_idx_q    <= rd_idx_d;
            sum_q       <= sum_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            div_cnt_q   <= div_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the vector buffer has no reset; entries are always written before they are read.
    always_ff @(posedge clk) begin
        if (accept) buf_mem_q[count_q[IDX_W-1:0]] <= in_data;
    end

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign busy         = busy_q;
    assign err_zero_sum = err_q;

endmodule

// File: tb/tb_softmax_normalizer.sv
// Self-checking bench for softmax_normalizer: directed and random vectors against an arithmetic reference model.
module tb_softmax_normalizer;

    localparam int VEC_LEN = 16;
    localparam int DATA_W  = 16;
    localparam int SUM_W   = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic              err_zero_sum;

    softmax_normalizer #(.VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .err_zero_sum(err_zero_sum)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int vec[$];
    int exp_q[$];
    longint exp_sum;
    time t_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: recip = floor(2^20 / sum); prob = min(1.0, x*recip / 1024) in S5.10.
    function automatic void build_expected();
        longint recip, p;
        exp_sum = 0;
        exp_q.delete();
        foreach (vec[i]) exp_sum += vec[i];
        recip = (exp_sum == 0) ? 0 : (longint'(1) << 20) / exp_sum;
        foreach (vec[i]) begin
            p = longint'(vec[i]) * recip;
`ifdef SOFTMAX_ROUND_EN
            p = p + 512;
`endif
            p = p >> 10;
            exp_q.push_back((p > 1024) ? 1024 : int'(p));
        end
    endfunction

    task automatic send_vector(input bit use_last, input string name);
        int n = vec.size();
        build_expected();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'(vec[i]);
            in_last  = use_last && (i == n - 1);
            check({name, "_in_ready_accum"}, 32'(in_ready), 1);
            @(posedge clk);
            t_acc = $time;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        check({name, "_in_ready_drop"}, 32'(in_ready), 0);
        check({name, "_busy_high"}, 32'(busy), 1);
    endtask

    task automatic drain_vector(input bit rand_ready, input string name);
        int n = vec.size();
        int idx = 0;
        int guard = 0;
        bit seen = 1'b0;
        bit stalled = 1'b0;
        logic [DATA_W-1:0] held = '0;
        while (idx < n && guard < 400) begin
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    check({name, "_latency"}, 32'(($time - t_acc - 5) / 10), (exp_sum == 0) ? 2 : 22);
                    check({name, "_err_zero_sum"}, 32'(err_zero_sum), 32'(exp_sum == 0));
                end
                if (stalled) check({name, "_stall_stable"}, 32'(out_data), 32'(held));
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready) begin
                    check($sformatf("%s_data%0d", name, idx), 32'(out_data), 32'(exp_q[idx]));
                    check($sformatf("%s_last%0d", name, idx), 32'(out_last), 32'(idx == n - 1));
                    check($sformatf("%s_in_ready_emit%0d", name, idx), 32'(in_ready), 0);
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end
            @(negedge clk);
            guard++;
        end
        if (idx < n) check({name, "_timeout"}, 0, 1);
        out_ready = 1'b1;
        check({name, "_in_ready_back"}, 32'(in_ready), 1);
        check({name, "_busy_low"}, 32'(busy), 0);
        check({name, "_out_valid_low"}, 32'(out_valid), 0);
        check({name, "_err_low"}, 32'(err_zero_sum), 0);
    endtask

    task automatic run_vector(input bit use_last, input bit rand_ready, input string name);
        send_vector(use_last, name);
        drain_vector(rand_ready, name);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_in_ready"}, 32'(in_ready), 1);
        check({name, "_out_valid"}, 32'(out_valid), 0);
        check({name, "_out_data"}, 32'(out_data), 0);
        check({name, "_out_last"}, 32'(out_last), 0);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_err"}, 32'(err_zero_sum), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        vec = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
        run_vector(1'b1, 1'b0, "four_ones");

        vec = '{16'h0400, 16'h0000};
        run_vector(1'b1, 1'b0, "one_zero");

        vec = '{0, 0, 0};
        run_vector(1'b1, 1'b0, "zero_sum");

        vec.delete();
        for (int i = 0; i < VEC_LEN; i++) vec.push_back(16'h0040);
        run_vector(1'b0, 1'b0, "full_no_last");

        vec = '{16'h0400, 16'h0400, 16'h0400};
        run_vector(1'b1, 1'b1, "thirds_stall");

        vec = '{16'h0400, 16'h0400, 16'h0400};
        send_vector(1'b1, "abort");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vec = '{16'h0200, 16'h0200};
        run_vector(1'b1, 1'b0, "after_abort");

        for (int r = 0; r < 8; r++) begin
            int n = int'($urandom_range(2, VEC_LEN));
            vec.delete();
            for (int i = 0; i < n; i++)
                vec.push_back(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 16'h0800)));
            run_vector((n < VEC_LEN) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
